// File: rtl/l1d_data_ram_sched.sv
// L1D data-RAM port scheduler: arbitrates linefill, hit and evict traffic
// onto one RAM pipe, keeping bursts atomic and metering evicts by credit.
module l1d_data_ram_sched #(
    parameter int PLD_W      = 512,
    parameter int EV_CRD_MAX = 4,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = $clog2(EV_CRD_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lf_vld,
    output logic             lf_rdy,
    input  logic [PLD_W-1:0] lf_pld,
    input  logic             lf_last,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [PLD_W-1:0] wr_pld,
    input  logic             ev_vld,
    output logic             ev_rdy,
    input  logic [PLD_W-1:0] ev_pld,
    input  logic             ev_last,
    input  logic             ev_crd_ret,
    output logic             ram_vld,
    input  logic             ram_rdy,
    output logic [PLD_W-1:0] ram_pld,
    output logic [1:0]       ram_src,
    output logic [CNT_W-1:0] ev_crd_cnt,
    output logic             crd_err,
    output logic             busy
);

    localparam int WAIT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LF   = 2'd1;
    localparam logic [1:0] S_EV   = 2'd2;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_LF   = 2'd1;
    localparam logic [1:0] SRC_WR   = 2'd2;
    localparam logic [1:0] SRC_EV   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  crd_q, crd_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic [1:0] src;
    logic       crd_ok;
    logic       starved;
    logic       xfer;
    logic       lf_xfer;
    logic       wr_xfer;
    logic       ev_xfer;

    assign crd_ok  = (crd_q != '0);
    assign starved = wr_vld && (wait_q == WAIT_W'(STARVE_MAX));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            crd_q   <= CNT_W'(EV_CRD_MAX);
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crd_q   <= crd_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Grant and handshake outputs; nothing is granted while in reset
    always_comb begin
        src = SRC_NONE;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (starved)               src = SRC_WR;
                    else if (lf_vld)           src = SRC_LF;
                    else if (ev_vld && crd_ok) src = SRC_EV;
                    else if (wr_vld)           src = SRC_WR;
                end
                S_LF:    if (lf_vld)           src = SRC_LF;
                S_EV:    if (ev_vld && crd_ok) src = SRC_EV;
                default: src = SRC_NONE;
            endcase
        end
    end

    always_comb begin
        ram_vld = 1'b0;
        ram_pld = '0;
        lf_rdy  = 1'b0;
        wr_rdy  = 1'b0;
        ev_rdy  = 1'b0;
        case (src)
            SRC_LF: begin
                ram_vld = lf_vld;
                ram_pld = lf_pld;
                lf_rdy  = ram_rdy;
            end
            SRC_WR: begin
                ram_vld = wr_vld;
                ram_pld = wr_pld;
                wr_rdy  = ram_rdy;
            end
            SRC_EV: begin
                ram_vld = ev_vld;
                ram_pld = ev_pld;
                ev_rdy  = ram_rdy;
            end
            default: ;
        endcase
    end

    assign ram_src    = src;
    assign ev_crd_cnt = crd_q;
    assign crd_err    = err_q;
    assign busy       = (state_q != S_IDLE);

    assign xfer    = ram_vld && ram_rdy;
    assign lf_xfer = xfer && (src == SRC_LF);
    assign wr_xfer = xfer && (src == SRC_WR);
    assign ev_xfer = xfer && (src == SRC_EV);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lf_xfer && !lf_last)      state_d = S_LF;
                else if (ev_xfer && !ev_last) state_d = S_EV;
            end
            S_LF:    if (lf_xfer && lf_last) state_d = S_IDLE;
            S_EV:    if (ev_xfer && ev_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Credit, starvation and error bookkeeping
    always_comb begin
        crd_d  = crd_q;
        err_d  = err_q;
        wait_d = wait_q;
        if (ev_xfer && !ev_crd_ret) begin
            crd_d = crd_q - CNT_W'(1);
        end else if (ev_crd_ret && !ev_xfer) begin
            if (crd_q == CNT_W'(EV_CRD_MAX)) err_d = 1'b1;
            else                             crd_d = crd_q + CNT_W'(1);
        end
        if (!wr_vld || wr_xfer) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(STARVE_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_l1d_data_ram_sched.sv
// Directed bench for l1d_data_ram_sched: priority, atomicity, credits,
// starvation promotion, credit overflow and mid-burst reset.
module tb_l1d_data_ram_sched;

    localparam int PLD_W = 512;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             lf_vld, lf_rdy, lf_last;
    logic             wr_vld, wr_rdy;
    logic             ev_vld, ev_rdy, ev_last;
    logic             ev_crd_ret;
    logic             ram_vld, ram_rdy;
    logic [PLD_W-1:0] lf_pld, wr_pld, ev_pld, ram_pld;
    logic [1:0]       ram_src;
    logic [CNT_W-1:0] ev_crd_cnt;
    logic             crd_err, busy;

    int nvec = 0;
    int nerr = 0;
    int lfbeat;
    logic [1:0] exp_src;

    always #5 clk = ~clk;

    l1d_data_ram_sched #(
        .PLD_W(PLD_W), .EV_CRD_MAX(4), .STARVE_MAX(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .lf_vld(lf_vld), .lf_rdy(lf_rdy), .lf_pld(lf_pld), .lf_last(lf_last),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_pld(wr_pld),
        .ev_vld(ev_vld), .ev_rdy(ev_rdy), .ev_pld(ev_pld), .ev_last(ev_last),
        .ev_crd_ret(ev_crd_ret),
        .ram_vld(ram_vld), .ram_rdy(ram_rdy), .ram_pld(ram_pld),
        .ram_src(ram_src), .ev_crd_cnt(ev_crd_cnt),
        .crd_err(crd_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic lv, input logic ll, input logic wv,
                       input logic ev, input logic el, input logic ret,
                       input logic rr);
        lf_vld     = lv;
        lf_last    = ll;
        wr_vld     = wv;
        ev_vld     = ev;
        ev_last    = el;
        ev_crd_ret = ret;
        ram_rdy    = rr;
    endtask

    initial begin
        lf_pld = PLD_W'(64'h1111);
        wr_pld = PLD_W'(64'h2222);
        ev_pld = PLD_W'(64'h3333);
        rst = 1'b1;
        drv(1, 0, 1, 1, 0, 0, 1);
        #1;
        chk("rst_ram_vld", 64'(ram_vld), 0);
        chk("rst_lf_rdy", 64'(lf_rdy), 0);
        chk("rst_wr_rdy", 64'(wr_rdy), 0);
        chk("rst_src", 64'(ram_src), 0);
        chk("rst_pld", ram_pld[63:0], 0);
        cyc();
        chk("rst_cnt", 64'(ev_crd_cnt), 4);
        chk("rst_err", 64'(crd_err), 0);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b0;

        // All three valid: LF burst first, then EV burst, then WR
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 3, 1, 1, 0, 0, 1);
            #1;
            chk("pri_lf_src", 64'(ram_src), 1);
            chk("pri_lf_rdy", 64'(lf_rdy), 1);
            chk("pri_lf_wr_rdy", 64'(wr_rdy), 0);
            chk("pri_lf_pld", ram_pld[63:0], 64'h1111);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 1, 1, i == 3, 0, 1);
            #1;
            chk("pri_ev_src", 64'(ram_src), 3);
            chk("pri_ev_rdy", 64'(ev_rdy), 1);
            chk("pri_ev_pld", ram_pld[63:0], 64'h3333);
            cyc();
        end
        chk("pri_ev_cnt0", 64'(ev_crd_cnt), 0);
        chk("pri_ev_idle", 64'(busy), 0);
        drv(0, 0, 1, 1, 0, 0, 1);
        #1;
        chk("pri_wr_src", 64'(ram_src), 2);
        chk("pri_wr_rdy", 64'(wr_rdy), 1);
        chk("pri_wr_ev_rdy", 64'(ev_rdy), 0);
        chk("pri_wr_pld", ram_pld[63:0], 64'h2222);
        cyc();

        // Credit stall in a 6-beat evict burst
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 0, 1, 1);
            cyc();
        end
        chk("stall_refill", 64'(ev_crd_cnt), 4);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 1, 0, 0, 1);
            #1;
            chk("stall_beat_src", 64'(ram_src), 3);
            cyc();
        end
        chk("stall_cnt0", 64'(ev_crd_cnt), 0);
        chk("stall_busy", 64'(busy), 1);
        drv(0, 0, 0, 1, 0, 0, 1);
        #1;
        chk("stall_ram_vld", 64'(ram_vld), 0);
        chk("stall_ev_rdy", 64'(ev_rdy), 0);
        cyc();
        drv(0, 0, 0, 1, 0, 1, 1);
        #1;
        chk("stall_ret_same", 64'(ram_vld), 0);
        cyc();
        chk("stall_cnt1", 64'(ev_crd_cnt), 1);
        drv(0, 0, 0, 1, 0, 1, 1);
        #1;
        chk("stall_b5_vld", 64'(ram_vld), 1);
        chk("stall_b5_src", 64'(ram_src), 3);
        cyc();
        chk("crd_simul", 64'(ev_crd_cnt), 1);
        drv(0, 0, 0, 1, 1, 0, 1);
        #1;
        chk("stall_b6_src", 64'(ram_src), 3);
        cyc();
        chk("stall_b6_cnt", 64'(ev_crd_cnt), 0);
        chk("stall_b6_idle", 64'(busy), 0);

        // LF burst with a 2-cycle gap while WR waits
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 0, 1, 1);
            cyc();
        end
        chk("gap_refill", 64'(ev_crd_cnt), 4);
        drv(1, 0, 1, 0, 0, 0, 1);
        #1;
        chk("gap_b1_src", 64'(ram_src), 1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 1, 0, 0, 0, 1);
            #1;
            chk("gap_ram_vld", 64'(ram_vld), 0);
            chk("gap_wr_rdy", 64'(wr_rdy), 0);
            chk("gap_busy", 64'(busy), 1);
            cyc();
        end
        drv(1, 1, 1, 0, 0, 0, 1);
        #1;
        chk("gap_b2_src", 64'(ram_src), 1);
        chk("gap_b2_busy", 64'(busy), 1);
        cyc();
        drv(0, 0, 1, 0, 0, 0, 1);
        #1;
        chk("gap_end_busy", 64'(busy), 0);
        chk("gap_wr_src", 64'(ram_src), 2);
        cyc();

        // Back-to-back LF bursts; WR promoted after 8 wait cycles
        lfbeat = 0;
        for (int c = 0; c < 10; c++) begin
            exp_src = (c == 8) ? 2'd2 : 2'd1;
            drv(1, lfbeat == 3, 1, 0, 0, 0, 1);
            #1;
            chk($sformatf("starve_c%0d", c), 64'(ram_src), 64'(exp_src));
            if (exp_src == 2'd1) lfbeat = (lfbeat + 1) % 4;
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drv(1, lfbeat == 3, 0, 0, 0, 0, 1);
            #1;
            chk("starve_tail_src", 64'(ram_src), 1);
            lfbeat = (lfbeat + 1) % 4;
            cyc();
        end
        chk("starve_tail_idle", 64'(busy), 0);

        // Credit return while already full
        drv(0, 0, 0, 0, 0, 1, 1);
        cyc();
        chk("ovf_cnt", 64'(ev_crd_cnt), 4);
        chk("ovf_err", 64'(crd_err), 1);
        drv(0, 0, 0, 0, 0, 0, 1);
        cyc();
        cyc();
        chk("ovf_err_sticky", 64'(crd_err), 1);

        // Reset in the middle of an evict burst
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 1, 0, 0, 1);
            cyc();
        end
        chk("rstb_cnt1", 64'(ev_crd_cnt), 1);
        chk("rstb_busy", 64'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rstb_ev_rdy_in_rst", 64'(ev_rdy), 0);
        cyc();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("rstb_busy0", 64'(busy), 0);
        chk("rstb_cnt4", 64'(ev_crd_cnt), 4);
        chk("rstb_err0", 64'(crd_err), 0);
        chk("rstb_lf_rdy", 64'(lf_rdy), 0);
        chk("rstb_wr_rdy", 64'(wr_rdy), 0);
        chk("rstb_ev_rdy", 64'(ev_rdy), 0);
        chk("rstb_src", 64'(ram_src), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
